// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch BCD paths.
// No logic; constants, types and one digit helper only.
// Not applicable (no handshake).
package stopwatch_pkg;

  localparam int DIGITS_C = 6;
  localparam int TIME_W_C = 20;
  localparam int IDX_W_C  = 3;

  typedef logic [3:0] bcd_t;

  typedef enum logic {
    EDIT = 1'b0,
    CONV = 1'b1
  } entry_state_t;

  // Decimal digit increment with 9 -> 0 wrap.
  function automatic bcd_t bcd_inc(input bcd_t d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/bcd_time_entry_if.sv
// Key pulses in, edit digits and converted preset out.
// Wires only; all timing lives in bcd_time_entry.
// Keys are plain pulses; no backpressure on this path.
interface bcd_time_entry_if
  import stopwatch_pkg::*;
#(
  parameter int TIME_W = TIME_W_C
);

  logic              key_sel;
  logic              key_inc;
  logic              key_load;
  bcd_t              ones;
  bcd_t              tens;
  bcd_t              hundreds;
  bcd_t              thousands;
  bcd_t              ten_thousands;
  bcd_t              hun_thousands;
  logic [IDX_W_C-1:0] sel_idx;
  logic [TIME_W-1:0] t_preset;
  logic              preset_valid;
  logic              busy;

  // Key source side (keypad / debouncer).
  modport master (
    output key_sel, key_inc, key_load,
    input  ones, tens, hundreds, thousands, ten_thousands, hun_thousands,
    input  sel_idx, t_preset, preset_valid, busy
  );

  // Entry block side.
  modport slave (
    input  key_sel, key_inc, key_load,
    output ones, tens, hundreds, thousands, ten_thousands, hun_thousands,
    output sel_idx, t_preset, preset_valid, busy
  );

endinterface

// File: rtl/bcd_time_entry_mac10.sv
// Combinational multiply-by-ten plus one BCD digit: y = acc*10 + d.
// Zero latency.
// No handshake; pure function of its inputs.
module mac10
  import stopwatch_pkg::*;
#(
  parameter int W = TIME_W_C
) (
  input  logic [W-1:0] acc,
  input  bcd_t         d,
  output logic [W-1:0] y,
  output logic         ovf
);

  logic [W+3:0] acc_x;
  logic [W+3:0] wide;

  // Shift-add times ten in a 4-bit-wider intermediate, then truncate.
  always_comb begin
    acc_x = {4'b0000, acc};
    wide  = (acc_x << 3) + (acc_x << 1) + {{W{1'b0}}, d};
  end

  assign y   = wide[W-1:0];
  assign ovf = |wide[W+3:W];

endmodule

// File: rtl/bcd_time_entry.sv
// Six-digit BCD preset editor with sequential Horner conversion to binary.
// Conversion takes DIGITS cycles after key_load; result and pulse registered.
// Keys are ignored (not queued) while busy; no other backpressure.
module bcd_time_entry
  import stopwatch_pkg::*;
#(
  parameter int DIGITS = DIGITS_C,
  parameter int TIME_W = TIME_W_C
) (
  input  logic          clk,
  input  logic          KEY2,
  bcd_time_entry_if.slave bus
);

  localparam logic [IDX_W_C-1:0] LAST_IDX = IDX_W_C'(DIGITS - 1);

  entry_state_t       state_q, state_d;
  bcd_t               digit_q [DIGITS];
  bcd_t               digit_d [DIGITS];
  logic [IDX_W_C-1:0] sel_q, sel_d;
  logic [IDX_W_C-1:0] cnt_q, cnt_d;
  logic [TIME_W-1:0]  acc_q, acc_d;
  logic [TIME_W-1:0]  preset_q, preset_d;
  logic               valid_q, valid_d;
  logic [TIME_W-1:0]  mac_y;
  logic               mac_ovf;

  // Digits stay frozen during CONV, so they feed the MAC directly.
  mac10 #(.W(TIME_W)) u_mac10 (
    .acc (acc_q),
    .d   (digit_q[cnt_q]),
    .y   (mac_y),
    .ovf (mac_ovf)
  );

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge KEY2) begin
    if (!KEY2) begin
      state_q  <= EDIT;
      sel_q    <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      preset_q <= '0;
      valid_q  <= 1'b0;
      for (int i = 0; i < DIGITS; i++) digit_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      preset_q <= preset_d;
      valid_q  <= valid_d;
      digit_q  <= digit_d;
    end
  end

  // Next state: key editing in EDIT (load wins), one digit per cycle in CONV.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    preset_d = preset_q;
    valid_d  = 1'b0;
    digit_d  = digit_q;
    case (state_q)
      EDIT: begin
        if (bus.key_load) begin
          acc_d   = '0;
          cnt_d   = LAST_IDX;
          state_d = CONV;
        end else begin
          // Increment uses the pre-advance index when both keys coincide.
          if (bus.key_inc) digit_d[sel_q] = bcd_inc(digit_q[sel_q]);
          if (bus.key_sel) sel_d = (sel_q == LAST_IDX) ? '0 : sel_q + IDX_W_C'(1);
        end
      end
      CONV: begin
        acc_d = mac_y;
        cnt_d = cnt_q - IDX_W_C'(1);
        if (cnt_q == '0) begin
          preset_d = mac_y;
          valid_d  = 1'b1;
          state_d  = EDIT;
        end
      end
      default: state_d = EDIT;
    endcase
  end

  // Width rule (10^DIGITS - 1 < 2^TIME_W) means the MAC never carries out.
  assert property (@(posedge clk) disable iff (!KEY2) !(state_q == CONV && mac_ovf));

  assign bus.ones          = digit_q[0];
  assign bus.tens          = digit_q[1];
  assign bus.hundreds      = digit_q[2];
  assign bus.thousands     = digit_q[3];
  assign bus.ten_thousands = digit_q[4];
  assign bus.hun_thousands = digit_q[5];
  assign bus.sel_idx       = sel_q;
  assign bus.t_preset      = preset_q;
  assign bus.preset_valid  = valid_q;
  assign bus.busy          = (state_q == CONV);

endmodule
